// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, segment patterns and scan FSM encoding for the display scanner
package display_pkg;

    localparam int DEF_TICK_DIV = 208333;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low a..g on bits 6..0
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_SHOW  = 2'd1,
        ST_OFF   = 2'd2
    } scan_state_t;

endpackage

// File: rtl/decodificador_7seg.sv
// rtl/decodificador_7seg.sv - combinational hex to active-low 7-segment decoder
module decodificador_7seg
    import display_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (hex_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/controlador_barrido_display.sv
// rtl/controlador_barrido_display.sv - double-buffered 7-segment scan controller; LEADING_ZERO_BLANK_EN suppresses leading zeros
module controlador_barrido_display
    import display_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int BLANK_CYC = 1000
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        enable_i,
    input  logic [4*N_DIGITS-1:0]       hex_in_i,
    input  logic [N_DIGITS-1:0]         dp_in_i,
    input  logic                        load_i,
    output logic [N_DIGITS-1:0]         an_o,
    output logic [6:0]                  seg_o,
    output logic                        dp_o,
    output logic [$clog2(N_DIGITS)-1:0] digit_idx_o,
    output logic                        frame_done_o
);

    localparam int IW = $clog2(N_DIGITS);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0]       CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]       CNT_SHOW = CW'(BLANK_CYC);
    localparam logic [IW-1:0]       DIG_LAST = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_ONE   = N_DIGITS'(1);

    scan_state_t             state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           digit_q, digit_d;
    logic                    boundary;

    logic [4*N_DIGITS-1:0]   shadow_hex_q, active_hex_q;
    logic [N_DIGITS-1:0]     shadow_dp_q, active_dp_q;
    logic                    pending_q;

    logic [N_DIGITS-1:0]     an_q;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic                    frame_done_q;

    logic [3:0]              cur_nib;
    logic [6:0]              cur_seg;
    logic                    cur_dp;
    logic [N_DIGITS-1:0]     suppress;
    logic                    cur_supp;

    // Coming back from OFF restarts at cnt 0 so the first slot gets its full dark interval
    always_comb begin
        cnt_d    = cnt_q;
        digit_d  = digit_q;
        state_d  = state_q;
        boundary = 1'b0;
        if (!enable_i) begin
            cnt_d   = '0;
            digit_d = '0;
            state_d = ST_OFF;
        end else if (state_q == ST_OFF) begin
            cnt_d   = '0;
            digit_d = '0;
            state_d = ST_BLANK;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            state_d  = ST_BLANK;
            boundary = (digit_q == DIG_LAST);
            digit_d  = boundary ? '0 : digit_q + 1'b1;
        end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_d < CNT_SHOW) ? ST_BLANK : ST_SHOW;
        end
    end

    assign cur_nib = active_hex_q[{digit_q, 2'b00} +: 4];
    assign cur_dp  = active_dp_q[digit_q];

    decodificador_7seg u_dec (
        .hex_i (cur_nib),
        .seg_o (cur_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic zeros_above;

    always_comb begin
        suppress    = '0;
        zeros_above = 1'b1;
        for (int k = N_DIGITS - 1; k > 0; k--) begin
            zeros_above = zeros_above && (active_hex_q[4*k +: 4] == 4'h0);
            suppress[k] = zeros_above;
        end
    end
`else
    assign suppress = '0;
`endif

    assign cur_supp = suppress[digit_q];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            digit_q      <= '0;
            shadow_hex_q <= '0;
            shadow_dp_q  <= '0;
            active_hex_q <= '0;
            active_dp_q  <= '0;
            pending_q    <= 1'b0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            frame_done_q <= boundary;

            // A load in the boundary cycle lands in shadow after active has copied the old shadow
            if (boundary && pending_q) begin
                active_hex_q <= shadow_hex_q;
                active_dp_q  <= shadow_dp_q;
            end
            if (load_i) begin
                shadow_hex_q <= hex_in_i;
                shadow_dp_q  <= dp_in_i;
                pending_q    <= 1'b1;
            end else if (boundary) begin
                pending_q    <= 1'b0;
            end

            an_q  <= '1;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            if (state_q == ST_SHOW && !(cur_supp && !cur_dp)) begin
                an_q  <= ~(AN_ONE << digit_q);
                seg_q <= cur_supp ? SEG_BLANK : cur_seg;
                dp_q  <= ~cur_dp;
            end
        end
    end

    assign an_o         = an_q;
    assign seg_o        = seg_q;
    assign dp_o         = dp_q;
    assign digit_idx_o  = digit_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_controlador_barrido_display.sv
// tb/tb_controlador_barrido_display.sv - directed self-checking bench for controlador_barrido_display
module tb_controlador_barrido_display;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] hex_in;
    logic [3:0]  dp_in;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [6:0] SEGT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct {
        int          la;
        logic [15:0] ha;
        logic [3:0]  da;
        int          lb;
        logic [15:0] hb;
        logic [3:0]  db;
        logic [15:0] eh;
        logic [3:0]  ed;
    } frame_t;

    controlador_barrido_display #(
        .N_DIGITS  (4),
        .TICK_DIV  (10),
        .BLANK_CYC (2)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .enable_i     (enable),
        .hex_in_i     (hex_in),
        .dp_in_i      (dp_in),
        .load_i       (load),
        .an_o         (an),
        .seg_o        (seg),
        .dp_o         (dp),
        .digit_idx_o  (digit_idx),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    // Expected {an, seg, dp} at frame cycle i (1..40) for displayed value h / decimal points p
    function automatic logic [11:0] exp_out(input int i, input logic [15:0] h, input logic [3:0] p);
        int         d;
        int         off;
        logic [3:0] nib;
        logic [3:0] an_e;
        logic       supp;
        d   = (i - 1) / 10;
        off = (i - 1) % 10;
        if (off < 2) return {4'b1111, 7'h7F, 1'b1};
        nib  = h[4*d +: 4];
        supp = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        supp = (d > 0) && ((h >> (4*d)) == 16'h0000);
`endif
        if (supp && !p[d]) return {4'b1111, 7'h7F, 1'b1};
        an_e    = 4'b1111;
        an_e[d] = 1'b0;
        return {an_e, supp ? 7'h7F : SEGT[nib], ~p[d]};
    endfunction

    task automatic sync_frame(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < budget);
        vectors++;
        if (frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL sync_frame: frame_done=%b after %0d cycles, required 1", frame_done, n);
        end
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        enable = 1'b1;
        load   = 1'b0;
        hex_in = 16'h1234;
        dp_in  = 4'b0000;
        repeat (3) @(negedge clk);
        vectors++;
        if ({an, seg, dp, digit_idx, frame_done} !== {4'b1111, 7'h7F, 1'b1, 2'b00, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: an=%b seg=%b dp=%b idx=%0d fd=%b, required an=1111 seg=1111111 dp=1 idx=0 fd=0",
                     an, seg, dp, digit_idx, frame_done);
        end
        reset = 1'b0;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        sync_frame(100);
    endtask

    // Each entry captures one full frame starting at a frame_done cycle, with up to two loads inside it
    task automatic test_frames;
        frame_t      tbl [8];
        logic [11:0] e;
        logic [1:0]  e_idx;
        logic        e_fd;
        tbl[0] = '{-1, 16'h0000, 4'h0, -1, 16'h0000, 4'h0, 16'h1234, 4'b0000};
        tbl[1] = '{ 5, 16'hAAAA, 4'hF, 20, 16'h00F0, 4'h0, 16'h1234, 4'b0000};
        tbl[2] = '{-1, 16'h0000, 4'h0, -1, 16'h0000, 4'h0, 16'h00F0, 4'b0000};
        tbl[3] = '{10, 16'h5678, 4'h5, 39, 16'h9ABC, 4'h0, 16'h00F0, 4'b0000};
        tbl[4] = '{-1, 16'h0000, 4'h0, -1, 16'h0000, 4'h0, 16'h5678, 4'b0101};
        tbl[5] = '{-1, 16'h0000, 4'h0, -1, 16'h0000, 4'h0, 16'h9ABC, 4'b0000};
        tbl[6] = '{ 0, 16'h0050, 4'h8, -1, 16'h0000, 4'h0, 16'h9ABC, 4'b0000};
        tbl[7] = '{-1, 16'h0000, 4'h0, -1, 16'h0000, 4'h0, 16'h0050, 4'b1000};
        for (int f = 0; f < 8; f++) begin
            for (int i = 1; i <= 40; i++) begin
                load = 1'b0;
                if (i - 1 == tbl[f].la) begin
                    load = 1'b1; hex_in = tbl[f].ha; dp_in = tbl[f].da;
                end
                if (i - 1 == tbl[f].lb) begin
                    load = 1'b1; hex_in = tbl[f].hb; dp_in = tbl[f].db;
                end
                @(negedge clk);
                e     = exp_out(i, tbl[f].eh, tbl[f].ed);
                e_idx = 2'((i % 40) / 10);
                e_fd  = (i == 40);
                vectors++;
                if ({an, seg, dp, digit_idx, frame_done} !== {e, e_idx, e_fd}) begin
                    miscompares++;
                    $display("FAIL frame%0d t=%0d: an=%b seg=%b dp=%b idx=%0d fd=%b, required an=%b seg=%b dp=%b idx=%0d fd=%b",
                             f, i, an, seg, dp, digit_idx, frame_done, e[11:8], e[7:1], e[0], e_idx, e_fd);
                end
            end
        end
        load = 1'b0;
    endtask

    task automatic test_enable;
        int n;
        repeat (14) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        vectors++;
        if (digit_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL enable_off_idx: idx=%0d, required 0", digit_idx);
        end
        for (int k = 16; k <= 29; k++) begin
            @(negedge clk);
            vectors++;
            if ({an, seg, dp, digit_idx, frame_done} !== {4'b1111, 7'h7F, 1'b1, 2'b00, 1'b0}) begin
                miscompares++;
                $display("FAIL enable_off t=%0d: an=%b seg=%b dp=%b idx=%0d fd=%b, required blank idx=0 fd=0",
                         k, an, seg, dp, digit_idx, frame_done);
            end
        end
        enable = 1'b1;
        for (int k = 30; k <= 32; k++) begin
            @(negedge clk);
            vectors++;
            if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
                miscompares++;
                $display("FAIL enable_restart_blank t=%0d: an=%b seg=%b dp=%b, required blank", k, an, seg, dp);
            end
        end
        @(negedge clk);
        vectors++;
        if ({an, seg, dp, digit_idx} !== {4'b1110, 7'b0000001, 1'b1, 2'b00}) begin
            miscompares++;
            $display("FAIL enable_restart_lit: an=%b seg=%b dp=%b idx=%0d, required an=1110 seg=0000001 dp=1 idx=0",
                     an, seg, dp, digit_idx);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 100);
        vectors++;
        if (n !== 37) begin
            miscompares++;
            $display("FAIL enable_restart_frame: frame_done after %0d cycles, required 37", n);
        end
    endtask

    task automatic test_reset_mid;
        logic [11:0] e;
        int          off;
        repeat (3) @(negedge clk);
        hex_in = 16'h1111;
        dp_in  = 4'b0000;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({an, seg, dp, digit_idx, frame_done} !== {4'b1111, 7'h7F, 1'b1, 2'b00, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid_values: an=%b seg=%b dp=%b idx=%0d fd=%b, required reset values",
                     an, seg, dp, digit_idx, frame_done);
        end
        reset = 1'b0;
        sync_frame(100);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            off = (i - 1) % 10;
            if (off < 2)
                e = {4'b1111, 7'h7F, 1'b1};
            else if (i <= 10)
                e = {4'b1110, 7'b0000001, 1'b1};
            else
`ifdef LEADING_ZERO_BLANK_EN
                e = {4'b1111, 7'h7F, 1'b1};
`else
                e = {4'b1101, 7'b0000001, 1'b1};
`endif
            vectors++;
            if ({an, seg, dp} !== e) begin
                miscompares++;
                $display("FAIL reset_mid_discard t=%0d: an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                         i, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_frames;
        test_enable;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
